// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle used by the line-burst master: AW/W/B write channels and AR/R read channels.
interface axi_burst_master_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 27
);
    localparam int STRB_W = DATA_W / 8;

    logic              awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic              bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic              arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready;

    logic              rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Moves whole cache lines to/from DRAM as AXI4 INCR bursts on independent write and read engines,
// stalling reads that hit the line of an in-flight write.
module axi_burst_master #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 27,
    parameter int BEATS  = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi_burst_master_if.master      m_axi,
    input  logic                    wr_en,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W*BEATS-1:0] wr_line,
    output logic                    wr_fin,
    output logic                    wr_err,
    input  logic                    rd_en,
    output logic                    rd_ready,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W*BEATS-1:0] rd_line,
    output logic                    rd_fin,
    output logic                    rd_err
);
    localparam int STRB_W     = DATA_W / 8;
    localparam int LINE_BYTES = STRB_W * BEATS;
    localparam int LINE_W     = DATA_W * BEATS;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [7:0]        BURST_LEN = 8'(BEATS - 1);
    localparam logic [2:0]        BEAT_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & LINE_MASK;
    endfunction

    w_state_e           w_state_q, w_state_d;
    logic [CNT_W-1:0]   w_cnt_q, w_cnt_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [LINE_W-1:0]  wr_line_q, wr_line_d;
    logic               wr_fin_q, wr_fin_d;
    logic               wr_err_q, wr_err_d;

    r_state_e           r_state_q, r_state_d;
    logic [CNT_W-1:0]   r_cnt_q, r_cnt_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0]  rd_line_q, rd_line_d;
    logic               r_err_acc_q, r_err_acc_d;
    logic               rd_fin_q, rd_fin_d;
    logic               rd_err_q, rd_err_d;

    logic               w_last;
    logic               r_last;
    logic               r_beat_err;
    logic               rd_hazard;
    logic               unused_ids;

    // Fixed burst attributes: one INCR burst of BEATS full-width beats per line.
    assign m_axi.awid    = 1'b0;
    assign m_axi.awlen   = BURST_LEN;
    assign m_axi.awsize  = BEAT_SIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awqos   = 4'b0000;
    assign m_axi.wstrb   = '1;
    assign m_axi.arid    = 1'b0;
    assign m_axi.arlen   = BURST_LEN;
    assign m_axi.arsize  = BEAT_SIZE;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arqos   = 4'b0000;

    // Handshake outputs decode registered state only, so no READY-to-VALID combinational path.
    assign m_axi.awvalid = (w_state_q == W_ADDR);
    assign m_axi.awaddr  = wr_addr_q;
    assign m_axi.wvalid  = (w_state_q == W_DATA);
    assign m_axi.wdata   = wr_line_q[w_cnt_q*DATA_W +: DATA_W];
    assign m_axi.wlast   = w_last;
    assign m_axi.bready  = (w_state_q == W_RESP);
    assign m_axi.arvalid = (r_state_q == R_ADDR);
    assign m_axi.araddr  = rd_addr_q;
    assign m_axi.rready  = (r_state_q == R_DATA);

    assign w_last     = (w_cnt_q == LAST_BEAT);
    assign r_last     = (r_cnt_q == LAST_BEAT);
    assign r_beat_err = (m_axi.rresp != 2'b00) || (m_axi.rlast != r_last);

    assign rd_hazard  = (w_state_q != W_IDLE) && (line_base(rd_addr) == wr_addr_q);
    assign wr_ready   = (w_state_q == W_IDLE);
    assign rd_ready   = (r_state_q == R_IDLE) && !rd_hazard;

    assign wr_fin     = wr_fin_q;
    assign wr_err     = wr_err_q;
    assign rd_fin     = rd_fin_q;
    assign rd_err     = rd_err_q;
    assign rd_line    = rd_line_q;

    assign unused_ids = m_axi.bid ^ m_axi.rid;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latch).
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_line_d = wr_line_q;
        wr_fin_d  = 1'b0;
        wr_err_d  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (wr_en) begin
                    wr_addr_d = line_base(wr_addr);
                    wr_line_d = wr_line;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (m_axi.awready) begin
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (m_axi.wready) begin
                    w_cnt_d = w_cnt_q + CNT_W'(1);
                    if (w_last) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (m_axi.bvalid) begin
                    wr_fin_d  = 1'b1;
                    wr_err_d  = (m_axi.bresp != 2'b00);
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_cnt_d     = r_cnt_q;
        rd_addr_d   = rd_addr_q;
        rd_line_d   = rd_line_q;
        r_err_acc_d = r_err_acc_q;
        rd_fin_d    = 1'b0;
        rd_err_d    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (rd_en && !rd_hazard) begin
                    rd_addr_d = line_base(rd_addr);
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (m_axi.arready) begin
                    r_cnt_d     = '0;
                    r_err_acc_d = 1'b0;
                    r_state_d   = R_DATA;
                end
            end
            R_DATA: begin
                // Completion follows the beat count; a misplaced RLAST is only reported.
                if (m_axi.rvalid) begin
                    rd_line_d[r_cnt_q*DATA_W +: DATA_W] = m_axi.rdata;
                    r_cnt_d     = r_cnt_q + CNT_W'(1);
                    r_err_acc_d = r_err_acc_q | r_beat_err;
                    if (r_last) begin
                        rd_fin_d  = 1'b1;
                        rd_err_d  = r_err_acc_q | r_beat_err;
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // NOTE: state is updated with nonblocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q   <= W_IDLE;
            w_cnt_q     <= '0;
            wr_addr_q   <= '0;
            // NOTE: line buffers are reset because they drive WDATA and rd_line directly.
            wr_line_q   <= '0;
            wr_fin_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            r_state_q   <= R_IDLE;
            r_cnt_q     <= '0;
            rd_addr_q   <= '0;
            rd_line_q   <= '0;
            r_err_acc_q <= 1'b0;
            rd_fin_q    <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            w_cnt_q     <= w_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_line_q   <= wr_line_d;
            wr_fin_q    <= wr_fin_d;
            wr_err_q    <= wr_err_d;
            r_state_q   <= r_state_d;
            r_cnt_q     <= r_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_line_q   <= rd_line_d;
            r_err_acc_q <= r_err_acc_d;
            rd_fin_q    <= rd_fin_d;
            rd_err_q    <= rd_err_d;
        end
    end
endmodule
